ttl_dreg_bank_sync: RTL and testbench

//  Parametrised bank of TTL-style D registers (74174/74273/74374 family) for clock-enable-driven board logic.

---
 rtl/ttl_pkg.sv | 40 ++++
 rtl/ttl_cen_edge_det.sv | 31 +++
 rtl/ttl_dreg_bank_sync.sv | 79 +++++++
 tb/tb_ttl_dreg_bank_sync.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL-style register bank.
// Holds the strobe event mode encodings, the event decode function and the
// reset value of the per-channel strobe history flop.
package ttl_pkg;

  localparam int unsigned TTL_EDGE_RISE  = 0;
  localparam int unsigned TTL_EDGE_FALL  = 1;
  localparam int unsigned TTL_EDGE_LEVEL = 2;

  localparam int unsigned TTL_MAX_CHANNELS = 16;

  // Decode a strobe event from the current strobe and its value one clock ago.
  function automatic logic ttl_event(input int unsigned mode,
                                     input logic        cen,
                                     input logic        last_cen);
    logic ev;
    ev = 1'b0;
    case (mode)
      TTL_EDGE_RISE:  ev = cen & ~last_cen;
      TTL_EDGE_FALL:  ev = ~cen & last_cen;
      TTL_EDGE_LEVEL: ev = cen;
      default:        ev = 1'b0;
    endcase
    return ev;
  endfunction

  // History value after reset, chosen so the first cycle out of reset never
  // decodes an edge regardless of where the strobe sits.
  function automatic logic ttl_last_cen_rst(input int unsigned mode);
    logic v;
    v = 1'b0;
    case (mode)
      TTL_EDGE_RISE: v = 1'b1;
      TTL_EDGE_FALL: v = 1'b0;
      default:       v = 1'b0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ttl_cen_edge_det.sv
// Per-channel strobe event detector.
// Ports:
//   Clk    - system clock
//   Reset  - synchronous reset, active-high
//   Cen    - strobe input for this channel
//   Event  - combinational event flag for the current clock (edge or level)
module ttl_cen_edge_det
  import ttl_pkg::*;
#(
  parameter int unsigned EDGE_MODE = TTL_EDGE_RISE
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Cen,
  output logic Event
);

  logic last_cen;

  // Strobe history; tracks Cen every non-reset cycle, including during clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_cen <= ttl_last_cen_rst(EDGE_MODE);
    end else begin
      last_cen <= Cen;
    end
  end

  assign Event = ttl_event(EDGE_MODE, Cen, last_cen);

endmodule

// File: rtl/ttl_dreg_bank_sync.sv
// Bank of independent TTL-style D registers loaded on strobe events.
// Ports:
//   Clk    - system clock, all state changes on posedge
//   Reset  - synchronous reset, active-high
//   Cen    - per-channel strobe (bit i -> channel i)
//   Clr_n  - per-channel synchronous clear, active-low
//   OE_n   - bank output enable, active-low, affects Y only
//   D      - data, channel i on D[i*WIDTH +: WIDTH]
//   Q      - raw register contents
//   Y      - Q, or FLOAT_VAL per channel while OE_n is high
//   Load   - one-cycle pulse registered alongside each channel load
module ttl_dreg_bank_sync
  import ttl_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       CHANNELS  = 1,
  parameter int unsigned       EDGE_MODE = TTL_EDGE_RISE,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter logic [WIDTH-1:0]  FLOAT_VAL = '1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [CHANNELS-1:0]          Cen,
  input  logic [CHANNELS-1:0]          Clr_n,
  input  logic                         OE_n,
  input  logic [CHANNELS*WIDTH-1:0]    D,
  output logic [CHANNELS*WIDTH-1:0]    Q,
  output logic [CHANNELS*WIDTH-1:0]    Y,
  output logic [CHANNELS-1:0]          Load
);

  localparam int unsigned BUS_W = CHANNELS * WIDTH;

  // Reject unsupported configurations at elaboration.
  if (EDGE_MODE > TTL_EDGE_LEVEL) begin : g_bad_edge_mode
    $error("ttl_dreg_bank_sync: EDGE_MODE %0d is not 0, 1 or 2", EDGE_MODE);
  end
  if ((CHANNELS < 1) || (CHANNELS > TTL_MAX_CHANNELS)) begin : g_bad_channels
    $error("ttl_dreg_bank_sync: CHANNELS %0d outside 1..16", CHANNELS);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic             cen_event;
    logic [WIDTH-1:0] q_r;
    logic             load_r;

    ttl_cen_edge_det #(
      .EDGE_MODE (EDGE_MODE)
    ) u_edge (
      .Clk   (Clk),
      .Reset (Reset),
      .Cen   (Cen[i]),
      .Event (cen_event)
    );

    // Register and load pulse: Reset > clear > event > hold.
    always_ff @(posedge Clk) begin
      if (Reset) begin
        q_r    <= RESET_VAL;
        load_r <= 1'b0;
      end else if (!Clr_n[i]) begin
        q_r    <= RESET_VAL;
        load_r <= 1'b0;
      end else if (cen_event) begin
        q_r    <= D[i*WIDTH +: WIDTH];
        load_r <= 1'b1;
      end else begin
        load_r <= 1'b0;
      end
    end

    assign Q[i*WIDTH +: WIDTH] = q_r;
    assign Load[i]             = load_r;
  end

  // Open-bus float value when the bank output is disabled.
  assign Y = OE_n ? BUS_W'({CHANNELS{FLOAT_VAL}}) : Q;

endmodule

// File: tb/tb_ttl_dreg_bank_sync.sv
// Self-checking bench: one bank per strobe mode, all driven in parallel,
// compared each clock against a behavioural model plus directed scenarios.
module tb_ttl_dreg_bank_sync;

  localparam int unsigned W  = 8;
  localparam int unsigned CH = 2;
  localparam logic [7:0]  RV = 8'h5C;
  localparam logic [7:0]  FV = 8'hFF;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  Cen;
  logic [1:0]  Clr_n;
  logic        OE_n;
  logic [15:0] D;

  logic [15:0] q0, q1, q2, y0, y1, y2;
  logic [1:0]  ld0, ld1, ld2;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural reference state: [mode][channel]
  logic [7:0] mq [3][2];
  logic       ml [3][2];
  logic       mprev [3][2];

  always #5 Clk = ~Clk;

  ttl_dreg_bank_sync #(.WIDTH(W), .CHANNELS(CH), .EDGE_MODE(0), .RESET_VAL(RV), .FLOAT_VAL(FV)) u_m0 (
    .Clk(Clk), .Reset(Reset), .Cen(Cen), .Clr_n(Clr_n), .OE_n(OE_n), .D(D), .Q(q0), .Y(y0), .Load(ld0));
  ttl_dreg_bank_sync #(.WIDTH(W), .CHANNELS(CH), .EDGE_MODE(1), .RESET_VAL(RV), .FLOAT_VAL(FV)) u_m1 (
    .Clk(Clk), .Reset(Reset), .Cen(Cen), .Clr_n(Clr_n), .OE_n(OE_n), .D(D), .Q(q1), .Y(y1), .Load(ld1));
  ttl_dreg_bank_sync #(.WIDTH(W), .CHANNELS(CH), .EDGE_MODE(2), .RESET_VAL(RV), .FLOAT_VAL(FV)) u_m2 (
    .Clk(Clk), .Reset(Reset), .Cen(Cen), .Clr_n(Clr_n), .OE_n(OE_n), .D(D), .Q(q2), .Y(y2), .Load(ld2));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, update the model from the applied inputs, then compare.
  task automatic step();
    logic [15:0] eq, oq, oy;
    logic [1:0]  el, ol;
    logic        rose, fell, ev;
    @(posedge Clk);
    for (int m = 0; m < 3; m++) begin
      for (int c = 0; c < 2; c++) begin
        if (Reset) begin
          mq[m][c]    = RV;
          ml[m][c]    = 1'b0;
          mprev[m][c] = (m == 0);
        end else begin
          rose = Cen[c] && !mprev[m][c];
          fell = !Cen[c] && mprev[m][c];
          ev   = (m == 0) ? rose : (m == 1) ? fell : Cen[c];
          mprev[m][c] = Cen[c];
          if (!Clr_n[c]) begin
            mq[m][c] = RV;
            ml[m][c] = 1'b0;
          end else if (ev) begin
            mq[m][c] = D[c*8 +: 8];
            ml[m][c] = 1'b1;
          end else begin
            ml[m][c] = 1'b0;
          end
        end
      end
    end
    #1;
    for (int m = 0; m < 3; m++) begin
      eq = {mq[m][1], mq[m][0]};
      el = {ml[m][1], ml[m][0]};
      case (m)
        0:       begin oq = q0; oy = y0; ol = ld0; end
        1:       begin oq = q1; oy = y1; ol = ld1; end
        default: begin oq = q2; oy = y2; ol = ld2; end
      endcase
      chk($sformatf("mode%0d_Q", m), oq, eq);
      chk($sformatf("mode%0d_Load", m), 16'(ol), 16'(el));
      chk($sformatf("mode%0d_Y", m), oy, OE_n ? {FV, FV} : eq);
    end
  endtask

  initial begin
    Reset = 1'b1; Cen = 2'b11; Clr_n = 2'b11; OE_n = 1'b0; D = 16'h0000;
    for (int m = 0; m < 3; m++)
      for (int c = 0; c < 2; c++) begin
        mq[m][c] = 8'hxx; ml[m][c] = 1'bx; mprev[m][c] = 1'bx;
      end

    // Reset held two clocks with strobes high
    step(); step();
    chk("reset_Q", q0, {RV, RV});
    chk("reset_Load", 16'(ld0 | ld1 | ld2), 16'h0000);

    // Release with strobes still high: no rising edge seen
    Reset = 1'b0; D = 16'h1234;
    step(); step(); step();
    chk("release_no_load", 16'(ld0), 16'h0000);

    // Mode0 rising edge on channel 0
    Cen = 2'b00; step();
    Cen = 2'b01; D = 16'h3CA5; step();
    chk("m0_rise_Q0", 16'(q0[7:0]), 16'h00A5);
    chk("m0_rise_Load", 16'(ld0), 16'h0001);
    chk("m0_rise_Q1_held", 16'(q0[15:8]), 16'(RV));
    D = 16'hEEEE;
    for (int k = 0; k < 5; k++) step();
    chk("m0_hold_no_reload", 16'(q0[7:0]), 16'h00A5);

    // Mode1 falling edge on channel 1
    Cen = 2'b11; step();
    Cen = 2'b01; D = 16'h5A00; step();
    chk("m1_fall_Q1", 16'(q1[15:8]), 16'h005A);
    chk("m1_fall_Load", 16'(ld1), 16'h0002);

    // Clear coincident with a rising edge consumes the edge
    Cen = 2'b00; step();
    Clr_n = 2'b10; Cen = 2'b01; D = 16'h0077; step();
    chk("clr_Q0", 16'(q0[7:0]), 16'(RV));
    chk("clr_Load0", 16'(ld0[0]), 16'h0000);
    Clr_n = 2'b11; step(); step();
    chk("clr_no_deferred", 16'(q0[7:0]), 16'(RV));

    // Mode2 level reload every clock
    D = 16'h0011; step();
    chk("m2_lvl_11", 16'(q2[7:0]), 16'h0011);
    D = 16'h0022; step();
    chk("m2_lvl_22", 16'(q2[7:0]), 16'h0022);
    D = 16'h0033; step();
    chk("m2_lvl_33", 16'(q2[7:0]), 16'h0033);
    chk("m2_lvl_Load", 16'(ld2[0]), 16'h0001);

    // Output float, and loads still happen while floated
    Cen = 2'b00; D = 16'hA55A; step();
    Cen = 2'b11; step();
    chk("oe_known_Q", q0, 16'hA55A);
    OE_n = 1'b1; step();
    chk("oe_float_Y", y0, 16'hFFFF);
    Cen = 2'b00; step();
    Cen = 2'b01; D = 16'h00C3; step();
    chk("oe_load_Q0", 16'(q0[7:0]), 16'h00C3);
    chk("oe_load_Y", y0, 16'hFFFF);
    OE_n = 1'b0;

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      Reset = ($urandom_range(0, 40) == 0);
      Cen   = 2'($urandom);
      Clr_n = {($urandom_range(0, 6) != 0), ($urandom_range(0, 6) != 0)};
      OE_n  = ($urandom_range(0, 3) == 0);
      D     = 16'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
